bcast_tree_sched: RTL and testbench
===================================

BCAST_TREE_SCHED -- requirements
Module: bcast_tree_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32, width of one data word.
REQ-002 SHALL have parameter NUM_REQ, 8, number of requesters; power of 2, at least 2.
REQ-003 SHALL have parameter TREE_LATENCY, 4, cycles from the tree input to the tree output; equals log2(fan-out) + 1 for the sequential 1-to-8 broadcast tree.
REQ-004 SHALL have one clock; reset is synchronous and active-high (ports clk, rst).
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 i_enable  input  1  scheduler enable; low requests an orderly drain and shutdown.
REQ-008 i_req_valid  input  NUM_REQ  per-requester valid.
REQ-009 i_req_data  input  NUM_REQ*DATA_WIDTH  per-requester word; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 o_req_ready  output  NUM_REQ  per-requester ready; one-hot or zero.
REQ-011 o_tree_valid  output  1  drives the tree i_valid.
REQ-012 o_tree_data  output  DATA_WIDTH  drives the tree i_data_bus.
REQ-013 o_tree_en  output  1  drives the tree i_en.
REQ-014 o_src_valid  output  1  source tag valid, aligned with the tree output valid.
REQ-015 o_src_id  output  clog2(NUM_REQ)  index of the requester whose word is at the tree output.
REQ-016 o_idle  output  1  high in state OFF.

Function
REQ-017 SHALL implement states OFF, RUN and DRAIN.
REQ-018 SHALL make these transitions: OFF->RUN when i_enable=1; RUN->DRAIN when i_enable=0; DRAIN->OFF when the in-flight count is 0; DRAIN->RUN never, so a DRAIN always completes before re-entering RUN.
REQ-019 SHALL drive o_tree_en=1 in RUN and DRAIN and 0 in OFF, and SHALL drive it from a register, so the tree is never flushed while data is in flight.
REQ-020 SHALL drive o_req_ready[k]=1 combinationally only when state=RUN, i_enable=1, and k is the round-robin winner among the asserted i_req_valid bits.
REQ-021 SHALL treat a transfer as accepted when i_req_valid[k] & o_req_ready[k]; at most one transfer is accepted per cycle.
REQ-022 SHALL perform round-robin arbitration: the winner is the lowest index at or after the pointer, wrapping modulo NUM_REQ.
REQ-023 SHALL set the pointer to (winner+1) mod NUM_REQ only on acceptance; the pointer is unchanged in idle cycles.
REQ-024 SHALL register an accepted word onto o_tree_data/o_tree_valid one cycle after acceptance; in every other cycle o_tree_valid=0 and o_tree_data=0.
REQ-025 SHALL pass the registered winner id and valid through a TREE_LATENCY-deep shift register, so that o_src_valid/o_src_id appear exactly 1+TREE_LATENCY cycles after acceptance, the same cycle as the tree output.
REQ-026 SHALL keep an in-flight counter of width clog2(TREE_LATENCY+2): +1 when o_tree_valid=1, -1 when o_src_valid=1, net 0 when both occur in the same cycle; it never underflows or overflows.
REQ-027 SHALL accept nothing in a cycle where i_enable falls while requests are pending; the pending requests stay pending.
REQ-028 SHALL drive o_src_id=0 whenever o_src_valid=0.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, set state=OFF, pointer=0, counter=0 and clear the shift register.
REQ-030 SHALL hold all outputs at 0 during reset, except o_idle, which is 1 during and after reset.
REQ-031 SHALL, when rst is asserted mid-operation, discard all in-flight tags; o_src_valid is 0 from the cycle after the reset edge.

Structure
REQ-032 SHALL define the state enum (OFF, RUN, DRAIN) and the default parameter constants in the shared package bcast_sched_pkg.
REQ-033 SHALL implement the arbiter as one sub-module, rr_arbiter: request vector and advance strobe in; one-hot grant and pointer out.

Verification
REQ-034 SHALL cover: reset, then i_enable=1 and requester 3 valid with 0xA5A5A5A5 accepted in cycle t -> o_tree_valid=1 at t+1; o_src_valid=1 and o_src_id=3 at t+5.
REQ-035 SHALL cover: all 8 requesters valid continuously -> grant order 0,1,...,7,0; one acceptance per cycle; no requester starved.
REQ-036 SHALL cover: requesters 2 and 6 valid with pointer=3 -> 6 is granted first, then 2.
REQ-037 SHALL cover: i_enable dropped 2 cycles after the last acceptance -> state DRAIN, o_tree_en stays 1 until the counter reaches 0, then OFF with o_tree_en=0 and o_idle=1; the last tag is delivered.
REQ-038 SHALL cover: rst pulsed with 3 words in flight -> the next cycle has o_src_valid=0, o_tree_en=0 and pointer=0; no stale tag ever appears.
REQ-039 SHALL cover: i_enable falling in the same cycle as a valid request -> no acceptance; the request is accepted after the next OFF->RUN transition.

Source files
------------

// File: rtl/bcast_sched_pkg.sv
// Shared types and default sizing for the broadcast-tree scheduler.
package bcast_sched_pkg;

  localparam int unsigned DEF_DATA_WIDTH   = 32;
  localparam int unsigned DEF_NUM_REQ      = 8;
  localparam int unsigned DEF_TREE_LATENCY = 4;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: lowest requesting index at or after the pointer wins;
// the pointer moves past the winner only when the grant is consumed.
module rr_arbiter
  import bcast_sched_pkg::*;
#(
  parameter int unsigned N = DEF_NUM_REQ
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant_c,
  output logic [$clog2(N)-1:0] ptr
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] idx;
  logic [IW-1:0] win;
  logic          found;

  // Scan from the pointer, wrapping naturally through the IW-bit sum.
  always_comb begin
    grant_c = '0;
    win     = '0;
    idx     = '0;
    found   = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      idx = ptr + IW'(i);
      if (!found && req[idx]) begin
        found        = 1'b1;
        grant_c[idx] = 1'b1;
        win          = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= win + IW'(1);
    end
  end

endmodule

// File: rtl/bcast_tree_sched.sv
// Schedules requester words into a sequential broadcast tree and tags each
// tree output with its source id; drains in-flight words before shutting down.
module bcast_tree_sched
  import bcast_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
  parameter int unsigned TREE_LATENCY = DEF_TREE_LATENCY
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_enable,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_tree_valid,
  output logic [DATA_WIDTH-1:0]         o_tree_data,
  output logic                          o_tree_en,
  output logic                          o_src_valid,
  output logic [$clog2(NUM_REQ)-1:0]    o_src_id,
  output logic                          o_idle
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(TREE_LATENCY + 2);

  sched_state_t            state;
  sched_state_t            state_nxt;
  logic [NUM_REQ-1:0]      grant_c;
  logic [IW-1:0]           unused_ptr;
  logic                    issue_ok;
  logic                    accept;
  logic [IW-1:0]           win_id;
  logic [DATA_WIDTH-1:0]   win_data;
  logic [IW-1:0]           tag_id;
  logic [CW-1:0]           inflight;
  logic [TREE_LATENCY-1:0] tag_vld;
  logic [IW-1:0]           tag_sr [TREE_LATENCY];

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (i_req_valid),
    .advance (accept),
    .grant_c (grant_c),
    .ptr     (unused_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= OFF;
    else     state <= state_nxt;
  end

  // A falling enable blocks issue in that very cycle; DRAIN never returns to RUN.
  always_comb begin
    state_nxt = state;
    unique case (state)
      OFF:     if (i_enable) state_nxt = RUN;
      RUN:     if (!i_enable) state_nxt = DRAIN;
      DRAIN:   if (inflight == '0) state_nxt = OFF;
      default: state_nxt = OFF;
    endcase
  end

  assign issue_ok    = (state == RUN) && i_enable && !rst;
  assign o_req_ready = issue_ok ? grant_c : '0;
  assign accept      = |(i_req_valid & o_req_ready);

  always_comb begin
    win_id   = '0;
    win_data = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (grant_c[k]) begin
        win_id   = IW'(k);
        win_data = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_tree_valid <= 1'b0;
      o_tree_data  <= '0;
      tag_id       <= '0;
      o_tree_en    <= 1'b0;
      o_idle       <= 1'b1;
      inflight     <= '0;
    end else begin
      o_tree_valid <= accept;
      o_tree_data  <= accept ? win_data : '0;
      tag_id       <= accept ? win_id : '0;
      o_tree_en    <= (state_nxt != OFF);
      o_idle       <= (state_nxt == OFF);
      unique case ({o_tree_valid, o_src_valid})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Tag delay line matched to the tree; ids are zero whenever the valid is.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      for (int i = 0; i < int'(TREE_LATENCY); i++) tag_sr[i] <= '0;
    end else begin
      tag_vld[0] <= o_tree_valid;
      tag_sr[0]  <= tag_id;
      for (int i = 1; i < int'(TREE_LATENCY); i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_sr[i]  <= tag_sr[i-1];
      end
    end
  end

  assign o_src_valid = tag_vld[TREE_LATENCY-1];
  assign o_src_id    = tag_sr[TREE_LATENCY-1];

endmodule

// File: tb/tb_bcast_tree_sched.sv
// Scoreboard bench for bcast_tree_sched: a cycle model predicts grants,
// tree output timing, source tags, drain timing and reset behaviour.
module tb_bcast_tree_sched;

  localparam int DW = 32;
  localparam int NR = 8;
  localparam int TL = 4;
  localparam int IW = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_enable;
  logic [NR-1:0]    i_req_valid;
  logic [NR*DW-1:0] i_req_data;
  logic [NR-1:0]    o_req_ready;
  logic             o_tree_valid;
  logic [DW-1:0]    o_tree_data;
  logic             o_tree_en;
  logic             o_src_valid;
  logic [IW-1:0]    o_src_id;
  logic             o_idle;

  always #5 clk = ~clk;

  bcast_tree_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TREE_LATENCY(TL)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (i_enable),
    .i_req_valid  (i_req_valid),
    .i_req_data   (i_req_data),
    .o_req_ready  (o_req_ready),
    .o_tree_valid (o_tree_valid),
    .o_tree_data  (o_tree_data),
    .o_tree_en    (o_tree_en),
    .o_src_valid  (o_src_valid),
    .o_src_id     (o_src_id),
    .o_idle       (o_idle)
  );

  typedef struct {
    int            due_tree;
    int            due_src;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } item_t;

  int            checks   = 0;
  int            failures = 0;
  item_t         sb[$];
  int            glog[$];
  int            m_state  = 0;
  logic [IW-1:0] m_ptr    = '0;
  int            cyc      = 0;
  int            src_seen = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One model cycle, evaluated at the negedge with this cycle's inputs.
  task automatic model_step();
    logic [NR-1:0] er;
    logic          etv;
    logic [DW-1:0] etd;
    logic          esv;
    logic [IW-1:0] esid;
    int            win;
    int            cnt;
    er  = '0;
    win = -1;
    if (m_state == 1 && i_enable && !rst) begin
      for (int i = 0; i < NR; i++) begin
        int idx;
        idx = (int'(m_ptr) + i) % NR;
        if (win < 0 && i_req_valid[idx]) begin
          win     = idx;
          er[idx] = 1'b1;
        end
      end
    end
    chk("req_ready", 64'(o_req_ready), 64'(er));
    if (|(o_req_ready & i_req_valid))
      for (int i = 0; i < NR; i++) if (o_req_ready[i]) glog.push_back(i);
    if (o_src_valid) src_seen++;

    etv = 1'b0;
    etd = '0;
    cnt = 0;
    foreach (sb[j]) begin
      if (sb[j].due_tree == cyc) begin
        etv = 1'b1;
        etd = sb[j].data;
      end
      if (sb[j].due_tree < cyc) cnt++;
    end
    chk("tree_valid", 64'(o_tree_valid), 64'(etv));
    chk("tree_data", 64'(o_tree_data), 64'(etd));

    esv  = 1'b0;
    esid = '0;
    if (sb.size() > 0 && sb[0].due_src == cyc) begin
      esv  = 1'b1;
      esid = sb[0].id;
      void'(sb.pop_front());
    end
    chk("src_valid", 64'(o_src_valid), 64'(esv));
    chk("src_id", 64'(o_src_id), 64'(esid));
    chk("tree_en", 64'(o_tree_en), 64'(m_state != 0));
    chk("idle", 64'(o_idle), 64'(m_state == 0));

    if (win >= 0) sb.push_back('{cyc + 1, cyc + 1 + TL, IW'(win), i_req_data[win*DW +: DW]});
    if (rst) begin
      m_state = 0;
      m_ptr   = '0;
      sb.delete();
    end else begin
      case (m_state)
        0: if (i_enable) m_state = 1;
        1: if (!i_enable) m_state = 2;
        default: if (cnt == 0) m_state = 0;
      endcase
      if (win >= 0) m_ptr = IW'(win + 1);
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!o_idle && n < budget) begin
      tick();
      n++;
    end
    chk("idle_reached", 64'(o_idle), 64'(1));
  endtask

  initial begin
    int n;
    int seen0;
    rst         = 1'b1;
    i_enable    = 1'b0;
    i_req_valid = '0;
    for (int k = 0; k < NR; k++) i_req_data[k*DW +: DW] = {8'(k), 8'hC3, 8'(k * 17), 8'h3C};
    repeat (2) @(posedge clk);
    #1;
    run(1);
    rst = 1'b0;
    run(1);

    // Single word from requester 3: tree at t+1, tag at t+5.
    i_req_data[3*DW +: DW] = 32'hA5A5A5A5;
    i_enable    = 1'b1;
    i_req_valid = 8'b0000_1000;
    glog.delete();
    run(2);
    i_req_valid = '0;
    run(6);
    chk("a5_grants", 64'(glog.size()), 64'(1));
    chk("a5_winner", 64'(glog.size() > 0 ? glog[0] : 99), 64'(3));

    // All requesters continuously valid from pointer 0.
    rst = 1'b1; i_enable = 1'b0;
    run(1);
    rst = 1'b0;
    glog.delete();
    i_enable    = 1'b1;
    i_req_valid = '1;
    run(10);
    i_req_valid = '0;
    chk("rr_count", 64'(glog.size()), 64'(9));
    for (int i = 0; i < 9; i++) chk("rr_order", 64'(i < glog.size() ? glog[i] : 99), 64'(i % NR));
    run(6);
    i_enable = 1'b0;
    wait_idle(20);

    // Pointer moved to 3 by serving requester 2; then 2 and 6 compete.
    i_enable    = 1'b1;
    i_req_valid = 8'b0000_0100;
    run(2);
    i_req_valid = '0;
    run(2);
    glog.delete();
    i_req_valid = 8'b0100_0100;
    run(2);
    i_req_valid = '0;
    chk("ptr3_first", 64'(glog.size() > 0 ? glog[0] : 99), 64'(6));
    chk("ptr3_second", 64'(glog.size() > 1 ? glog[1] : 99), 64'(2));
    run(6);

    // Enable dropped two cycles after the last acceptance.
    i_req_valid = 8'b0010_0000;
    run(1);
    i_req_valid = '0;
    run(1);
    seen0    = src_seen;
    i_enable = 1'b0;
    n = 0;
    while (!o_idle && n < 20) begin
      tick();
      n++;
    end
    chk("drain_cycles", 64'(n), 64'(5));
    chk("drain_last_tag", 64'(src_seen - seen0), 64'(1));
    chk("drain_tree_en", 64'(o_tree_en), 64'(0));
    run(2);

    // Reset with three words in flight.
    i_enable    = 1'b1;
    i_req_valid = '1;
    run(4);
    i_req_valid = '0;
    rst = 1'b1;
    run(1);
    rst = 1'b0; i_enable = 1'b0;
    chk("rst_src_valid", 64'(o_src_valid), 64'(0));
    chk("rst_tree_en", 64'(o_tree_en), 64'(0));
    seen0 = src_seen;
    run(8);
    chk("rst_no_stale", 64'(src_seen - seen0), 64'(0));
    glog.delete();
    i_enable    = 1'b1;
    i_req_valid = '1;
    run(2);
    i_req_valid = '0;
    chk("rst_ptr", 64'(glog.size() > 0 ? glog[0] : 99), 64'(0));
    run(6);
    i_enable = 1'b0;
    wait_idle(20);

    // Enable falls in the same cycle a request appears.
    i_enable = 1'b1;
    run(2);
    glog.delete();
    i_req_valid = 8'b0000_0010;
    i_enable    = 1'b0;
    wait_idle(20);
    chk("fall_no_accept", 64'(glog.size()), 64'(0));
    i_enable = 1'b1;
    run(2);
    i_req_valid = '0;
    chk("fall_later_accept", 64'(glog.size() > 0 ? glog[0] : 99), 64'(1));
    run(6);
    i_enable = 1'b0;
    wait_idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
